// File: rtl/poly_nco.sv
// Multi-voice phase-accumulator oscillator: per-voice saw/square/triangle/sine
// waveforms, swept one voice per clock and mixed into one signed sample per period.
module poly_nco #(
  parameter int VOICES     = 4,
  parameter int PHASE_W    = 24,
  parameter int OUT_W      = 16,
  parameter int SAMPLE_DIV = 1024
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en,
  input  logic                      cfg_we,
  input  logic [$clog2(VOICES)-1:0] cfg_voice,
  input  logic [PHASE_W-1:0]        cfg_inc,
  input  logic [1:0]                cfg_mode,
  input  logic                      cfg_gate,
  output logic [OUT_W-1:0]          mix_o,
  output logic                      sample_tick
);

  localparam int VW = $clog2(VOICES);
  localparam int CW = $clog2(SAMPLE_DIV);
  localparam int AW = OUT_W + VW;

  localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_VLAST = CW'(VOICES);
  localparam logic [CW-1:0] CNT_MIX   = CW'(VOICES + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(SAMPLE_DIV - 1);

  localparam logic [1:0] MODE_SAW = 2'b00;
  localparam logic [1:0] MODE_SQR = 2'b01;
  localparam logic [1:0] MODE_TRI = 2'b10;
  localparam logic [1:0] MODE_SIN = 2'b11;

  localparam logic [OUT_W-1:0]        SQ_POS = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0]        SQ_NEG = {1'b1, {(OUT_W-2){1'b0}}, 1'b1};
  localparam logic signed [OUT_W:0]   H_W    = {2'b01, {(OUT_W-1){1'b0}}};
  localparam logic signed [2*OUT_W:0] SAT_HI = {{(OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [2*OUT_W:0] SAT_LO = {{(OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

  // Waveform value for the top OUT_W phase bits p; sine is a parabola -s*(H-|s|).
  function automatic logic [OUT_W-1:0] wave_f(input logic [OUT_W-1:0] p,
                                               input logic [1:0]       mode);
    logic [OUT_W-2:0]         t;
    logic signed [OUT_W:0]    s_w;
    logic signed [OUT_W:0]    neg_w;
    logic signed [OUT_W:0]    mag_w;
    logic signed [OUT_W:0]    rem_w;
    logic signed [2*OUT_W:0]  prod_w;
    logic signed [2*OUT_W:0]  shf_w;
    logic [OUT_W-1:0]         y;
    t      = p[OUT_W-1] ? ~p[OUT_W-2:0] : p[OUT_W-2:0];
    s_w    = {~p[OUT_W-1], ~p[OUT_W-1], p[OUT_W-2:0]};
    neg_w  = -s_w;
    mag_w  = s_w[OUT_W] ? neg_w : s_w;
    rem_w  = H_W - mag_w;
    prod_w = {{OUT_W{neg_w[OUT_W]}}, neg_w} * {{OUT_W{rem_w[OUT_W]}}, rem_w};
    shf_w  = prod_w >>> (OUT_W - 3);
    case (mode)
      MODE_SAW: y = s_w[OUT_W-1:0];
      MODE_SQR: y = p[OUT_W-1] ? SQ_NEG : SQ_POS;
      MODE_TRI: y = {~t[OUT_W-2], t[OUT_W-3:0], 1'b0};
      MODE_SIN: begin
        if (shf_w > SAT_HI) begin
          y = SAT_HI[OUT_W-1:0];
        end else if (shf_w < SAT_LO) begin
          y = SAT_LO[OUT_W-1:0];
        end else begin
          y = shf_w[OUT_W-1:0];
        end
      end
      default:  y = {OUT_W{1'b0}};
    endcase
    return y;
  endfunction

  logic [PHASE_W-1:0] sh_inc_q   [VOICES];
  logic [PHASE_W-1:0] sh_inc_d   [VOICES];
  logic [1:0]         sh_mode_q  [VOICES];
  logic [1:0]         sh_mode_d  [VOICES];
  logic               sh_gate_q  [VOICES];
  logic               sh_gate_d  [VOICES];
  logic [PHASE_W-1:0] act_inc_q  [VOICES];
  logic [PHASE_W-1:0] act_inc_d  [VOICES];
  logic [1:0]         act_mode_q [VOICES];
  logic [1:0]         act_mode_d [VOICES];
  logic               act_gate_q [VOICES];
  logic               act_gate_d [VOICES];
  logic [PHASE_W-1:0] phase_q    [VOICES];
  logic [PHASE_W-1:0] phase_d    [VOICES];
  logic [AW-1:0]      acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [OUT_W-1:0]   mix_q, mix_d;
  logic               tick_q, tick_d;

  logic [VW-1:0]      vidx_s;
  logic [PHASE_W-1:0] new_phase_s;
  logic [OUT_W-1:0]   contrib_s;

  // Next-state: shadow writes always; sweep schedule only while enabled.
  always_comb begin
    sh_inc_d    = sh_inc_q;
    sh_mode_d   = sh_mode_q;
    sh_gate_d   = sh_gate_q;
    act_inc_d   = act_inc_q;
    act_mode_d  = act_mode_q;
    act_gate_d  = act_gate_q;
    phase_d     = phase_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    mix_d       = mix_q;
    tick_d      = 1'b0;
    vidx_s      = VW'(cnt_q - CNT_ONE);
    new_phase_s = {PHASE_W{1'b0}};
    contrib_s   = {OUT_W{1'b0}};

    if (cfg_we) begin
      sh_inc_d[cfg_voice]  = cfg_inc;
      sh_mode_d[cfg_voice] = cfg_mode;
      sh_gate_d[cfg_voice] = cfg_gate;
    end else begin
      sh_gate_d = sh_gate_q;
    end

    if (en) begin
      cnt_d = (cnt_q == CNT_LAST) ? {CW{1'b0}} : cnt_q + CNT_ONE;
      if (cnt_q == {CW{1'b0}}) begin
        act_inc_d  = sh_inc_q;
        act_mode_d = sh_mode_q;
        act_gate_d = sh_gate_q;
        acc_d      = {AW{1'b0}};
      end else if (cnt_q <= CNT_VLAST) begin
        // A silent voice is parked at phase 0 so a re-gate restarts cleanly.
        if (act_gate_q[vidx_s]) begin
          new_phase_s = phase_q[vidx_s] + act_inc_q[vidx_s];
          contrib_s   = wave_f(new_phase_s[PHASE_W-1 -: OUT_W], act_mode_q[vidx_s]);
        end else begin
          new_phase_s = {PHASE_W{1'b0}};
          contrib_s   = {OUT_W{1'b0}};
        end
        phase_d[vidx_s] = new_phase_s;
        acc_d = acc_q + {{VW{contrib_s[OUT_W-1]}}, contrib_s};
      end else if (cnt_q == CNT_MIX) begin
        mix_d  = acc_q[AW-1 -: OUT_W];
        tick_d = 1'b1;
      end else begin
        tick_d = 1'b0;
      end
    end else begin
      cnt_d  = cnt_q;
      tick_d = 1'b0;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < VOICES; i++) begin
        sh_inc_q[i]   <= {PHASE_W{1'b0}};
        sh_mode_q[i]  <= 2'b00;
        sh_gate_q[i]  <= 1'b0;
        act_inc_q[i]  <= {PHASE_W{1'b0}};
        act_mode_q[i] <= 2'b00;
        act_gate_q[i] <= 1'b0;
        phase_q[i]    <= {PHASE_W{1'b0}};
      end
      acc_q  <= {AW{1'b0}};
      cnt_q  <= {CW{1'b0}};
      mix_q  <= {OUT_W{1'b0}};
      tick_q <= 1'b0;
    end else begin
      sh_inc_q   <= sh_inc_d;
      sh_mode_q  <= sh_mode_d;
      sh_gate_q  <= sh_gate_d;
      act_inc_q  <= act_inc_d;
      act_mode_q <= act_mode_d;
      act_gate_q <= act_gate_d;
      phase_q    <= phase_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      mix_q      <= mix_d;
      tick_q     <= tick_d;
    end
  end

  assign mix_o       = mix_q;
  assign sample_tick = tick_q;

endmodule

// File: tb/tb_poly_nco.sv
// Directed bench for poly_nco (4 voices, 16-bit phase/output, 16 clocks per sample).
module tb_poly_nco;

  localparam int VOICES     = 4;
  localparam int PHASE_W    = 16;
  localparam int OUT_W      = 16;
  localparam int SAMPLE_DIV = 16;

  localparam logic [1:0] SAW = 2'b00;
  localparam logic [1:0] SQR = 2'b01;
  localparam logic [1:0] TRI = 2'b10;
  localparam logic [1:0] SIN = 2'b11;

  logic        clk       = 1'b0;
  logic        reset     = 1'b0;
  logic        en        = 1'b0;
  logic        cfg_we    = 1'b0;
  logic [1:0]  cfg_voice = 2'd0;
  logic [15:0] cfg_inc   = 16'd0;
  logic [1:0]  cfg_mode  = 2'd0;
  logic        cfg_gate  = 1'b0;
  logic [15:0] mix_o;
  logic        sample_tick;

  int tests_run    = 0;
  int tests_failed = 0;

  poly_nco #(
    .VOICES(VOICES), .PHASE_W(PHASE_W), .OUT_W(OUT_W), .SAMPLE_DIV(SAMPLE_DIV)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .cfg_we(cfg_we), .cfg_voice(cfg_voice),
    .cfg_inc(cfg_inc), .cfg_mode(cfg_mode), .cfg_gate(cfg_gate),
    .mix_o(mix_o), .sample_tick(sample_tick)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cfg_write(input logic [1:0] v, input logic [15:0] inc,
                           input logic [1:0] mode, input logic gate);
    cfg_we = 1'b1; cfg_voice = v; cfg_inc = inc; cfg_mode = mode; cfg_gate = gate;
    step(1);
    cfg_we = 1'b0;
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      step(1);
      n++;
    end while (!sample_tick && n < 64);
    if (!sample_tick) check_eq("tick_timeout", {15'd0, sample_tick}, 16'd1);
  endtask

  task automatic expect_sample(input string tag, input logic [15:0] exp);
    int n;
    wait_tick(n);
    check_eq(tag, mix_o, exp);
  endtask

  task automatic gate_all_off();
    for (int v = 0; v < VOICES; v++) cfg_write(2'(v), 16'h0000, SAW, 1'b0);
  endtask

  initial begin
    int n;
    int ph;
    int e;
    logic [15:0] sq_exp [4];
    logic [15:0] sin_exp [5];
    logic [15:0] tri_exp [4];
    sq_exp  = '{16'h7FFF, 16'h8001, 16'h8001, 16'h7FFF};
    sin_exp = '{16'h1FFF, 16'h0000, 16'hE000, 16'h0000, 16'h1FFF};
    tri_exp = '{16'h0000, 16'h1FFF, 16'hFFFF, 16'hE000};

    // Reset state and tick cadence after release.
    step(2);
    check_eq("rst_mix", mix_o, 16'h0000);
    check_eq("rst_tick", {15'd0, sample_tick}, 16'd0);
    en = 1'b1;
    reset = 1'b1;
    wait_tick(n);
    check_eq("first_tick_edges", 16'(n), 16'd6);
    check_eq("idle_mix", mix_o, 16'h0000);
    wait_tick(n);
    check_eq("tick_period", 16'(n), 16'd16);

    // Saw on voice 0 through a full phase wrap.
    cfg_write(2'd0, 16'h1000, SAW, 1'b1);
    for (int k = 1; k <= 17; k++) begin
      wait_tick(n);
      ph = (k * 4096) % 65536;
      e  = (ph - 32768) >>> 2;
      check_eq("saw", mix_o, 16'(e));
    end

    // All four voices square at full scale.
    gate_all_off();
    expect_sample("sq_off", 16'h0000);
    for (int v = 0; v < VOICES; v++) cfg_write(2'(v), 16'h4000, SQR, 1'b1);
    for (int k = 0; k < 4; k++) expect_sample("square", sq_exp[k]);

    // Sine with saturation at the positive peak.
    gate_all_off();
    expect_sample("sin_off", 16'h0000);
    cfg_write(2'd0, 16'h4000, SIN, 1'b1);
    for (int k = 0; k < 5; k++) expect_sample("sine", sin_exp[k]);

    // Triangle on voice 2.
    cfg_write(2'd0, 16'h4000, SIN, 1'b0);
    expect_sample("tri_off", 16'h0000);
    cfg_write(2'd2, 16'h4000, TRI, 1'b1);
    for (int k = 0; k < 4; k++) expect_sample("triangle", tri_exp[k]);

    // Config timing: mid-sweep write, gate-off, last-write-wins, re-gate.
    cfg_write(2'd2, 16'h4000, TRI, 1'b0);
    cfg_write(2'd0, 16'h1000, SAW, 1'b1);
    cfg_write(2'd1, 16'h2000, SAW, 1'b0);
    expect_sample("cfg_base", 16'hE400);
    step(13);
    cfg_write(2'd1, 16'h2000, SAW, 1'b1);
    wait_tick(n);
    check_eq("cfg_midsweep_edges", 16'(n), 16'd2);
    check_eq("cfg_midsweep_excl", mix_o, 16'hE800);
    expect_sample("cfg_next_incl", 16'hD400);
    cfg_write(2'd1, 16'h2000, SAW, 1'b1);
    cfg_write(2'd1, 16'h2000, SAW, 1'b0);
    expect_sample("cfg_gate_off", 16'hF000);
    cfg_write(2'd1, 16'h2000, SAW, 1'b1);
    expect_sample("cfg_regate", 16'hDC00);

    // Enable freeze mid-sweep, then resume at the held count.
    step(12);
    en = 1'b0;
    for (int k = 0; k < 40; k++) begin
      step(1);
      check_eq("freeze_tick", {15'd0, sample_tick}, 16'd0);
      check_eq("freeze_mix", mix_o, 16'hDC00);
    end
    en = 1'b1;
    wait_tick(n);
    check_eq("resume_edges", 16'(n), 16'd4);
    check_eq("resume_mix", mix_o, 16'hE800);
    wait_tick(n);
    check_eq("resume_period", 16'(n), 16'd16);
    check_eq("resume_mix2", mix_o, 16'hF400);

    // Asynchronous reset mid-sweep with voices sounding.
    step(12);
    #2 reset = 1'b0;
    #1;
    check_eq("async_rst_mix", mix_o, 16'h0000);
    check_eq("async_rst_tick", {15'd0, sample_tick}, 16'd0);
    step(3);
    reset = 1'b1;
    wait_tick(n);
    check_eq("rerst_first_edges", 16'(n), 16'd6);
    check_eq("rerst_mix", mix_o, 16'h0000);
    wait_tick(n);
    check_eq("rerst_period", 16'(n), 16'd16);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/poly_nco.md
# poly_nco

Multi-voice, parametrised numerically-controlled oscillator for the synthesizer audio path. It generates VOICES independent tones from per-voice phase accumulators, each with its own selectable waveform (saw, square, triangle, parabolic sine). It mixes the enabled voices into one signed sample per sample period and flags each sample with a one-cycle strobe. It sits between the note/keyboard controller, which writes voice configuration, and the audio DAC/codec interface.

## Interface
Parameters:
- VOICES, 4, number of voices; power of 2, ≥ 2
- PHASE_W, 24, phase accumulator and increment width
- OUT_W, 16, sample width (signed, two's complement); OUT_W ≤ PHASE_W
- SAMPLE_DIV, 1024, clk cycles per output sample; ≥ VOICES+2

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- en  in  1  run enable; low freezes all sequential state
- cfg_we  in  1  config write strobe
- cfg_voice  in  log2(VOICES)  voice index for the write
- cfg_inc  in  PHASE_W  phase increment per sample
- cfg_mode  in  2  waveform: 00 saw, 01 square, 10 triangle, 11 sine
- cfg_gate  in  1  1 = voice sounding, 0 = voice silent
- mix_o  out  OUT_W  signed mixed sample
- sample_tick  out  1  one-cycle pulse: mix_o was updated on this edge

## Operation
- **Shadow registers:**
  - Each voice has shadow {inc, mode, gate} registers.
  - cfg_we=1 writes the shadow set for cfg_voice on that edge, regardless of en.
- **Active set:** Shadows are copied to the active set at the start of each sweep, so a write never affects a sample already in progress.
- **Phase:**
  - Each voice holds an unsigned PHASE_W-bit phase.
  - When the active gate=1: phase ← (phase + inc) mod 2^PHASE_W.
  - When the active gate=0: phase ← 0 and the voice contributes 0.
  - A gated-on voice therefore starts from phase 0, and its first sample uses phase = inc.
- **Waveform (from the new phase):** Let p = phase[PHASE_W-1 -: OUT_W], unsigned, and H = 2^(OUT_W-1).
  - saw: s = p − H, giving range [−H, H−1].
  - square: +(H−1) if p < H, else −(H−1).
  - triangle: t = p[MSB] ? ~p[OUT_W-2:0] : p[OUT_W-2:0]; output = 2t − H.
  - sine: y = (−s)·(H − |s|) >>> (OUT_W−3), saturated to [−H, H−1], where s is the saw value. This needs an OUT_W+1-bit |s| and a 2·OUT_W+1-bit product.
- **Mix:**
  - The accumulator is OUT_W+log2(VOICES) bits wide; each contribution is sign-extended into it.
  - mix_o = acc >>> log2(VOICES) (arithmetic shift), so the mix cannot overflow.
- **Output frequency:** f = inc·Fclk / (SAMPLE_DIV·2^PHASE_W).

## Timing
- **Sample counter:**
  - cnt counts 0..SAMPLE_DIV−1, then wraps to 0.
  - It advances only when en=1. When en=0, cnt, the phases, acc and mix_o all hold, and sample_tick is 0.
- **Sweep schedule:** All steps below occur only on edges with en=1.
  - Edge at cnt==0: active set ← shadows; acc ← 0.
  - Edges at cnt==1..VOICES: process voice cnt−1 (phase update, then add its contribution to acc). One voice per cycle.
  - Edge at cnt==VOICES+1: mix_o ← acc >>> log2(VOICES); sample_tick ← 1.
  - All other edges: sample_tick ← 0. sample_tick is never high for two consecutive cycles.
- **Latency:**
  - A config write lands in the sample of the next sweep start, at most SAMPLE_DIV+VOICES+2 cycles after the write.
  - sample_tick period is exactly SAMPLE_DIV cycles while en=1.
- **Same-edge events:**
  - A write coinciding with the cnt==0 edge is NOT captured into that sweep.
  - Two writes to the same voice before a sweep: the last one wins.
- **Reset (any time, including mid-sweep):**
  - All shadows, active set, phases, acc, cnt, mix_o and sample_tick go to 0 immediately.
  - The first sweep starts on the first en=1 edge after release.

## Test plan
Bench parameters: VOICES=4, PHASE_W=16, OUT_W=16, SAMPLE_DIV=16.
- **Reset:** assert reset mid-sweep with voices active → mix_o=0 and sample_tick=0 asynchronously. After release with en=1, the first sample_tick occurs 6 edges after release, then every 16 cycles.
- **Saw wrap:** voice0 saw, inc=0x1000, gate=1, others off → successive mix_o = −0x1C00, −0x1800, … After 16 samples the phase wraps back to 0x1000 and the −0x1C00 value repeats.
- **Square, full scale:** all 4 voices square, inc=0x4000 → first sample 0x7FFF, second (phase 0x8000) 0x8001.
- **Sine:** voice0 sine, inc=0x4000 → samples 0x1FFF (saturated 32767/4), 0, −8192, 0, then repeat.
- **Config timing:** write voice1 gate=1 during cnt==3 → no effect on the current sample; takes effect in the next sample. Then write gate=0 → the next sample excludes voice1, and a re-gate restarts its phase at inc.
- **Enable freeze:** drop en for 40 cycles mid-sweep → no sample_tick and mix_o constant. After en returns, the sweep resumes at the held cnt with identical sample values.
